// File: rtl/branch_resolve_update_if.sv
// Resolve-stage and BTB-write bundle for branch_resolve_update.
// Handshakes: a transfer happens on a posedge where valid=1 and ready=1; valid never waits on ready.
interface branch_resolve_update_if;
  logic        resolve_valid;
  logic        resolve_ready;
  logic [15:0] resolve_PC;
  logic [15:0] resolve_target;
  logic        resolve_taken;
  logic [15:0] predicted_PC;
  logic        mispredict;
  logic [15:0] redirect_PC;
  logic        btb_wr_valid;
  logic        btb_wr_ready;
  logic [7:0]  btb_wr_index;
  logic [7:0]  btb_wr_tag;
  logic [15:0] btb_wr_target;
  logic        pred_taken_hint;
  logic [1:0]  counter_state;

  modport slave (
    input  resolve_valid, resolve_PC, resolve_target, resolve_taken, predicted_PC, btb_wr_ready,
    output resolve_ready, mispredict, redirect_PC, btb_wr_valid, btb_wr_index, btb_wr_tag,
           btb_wr_target, pred_taken_hint, counter_state
  );

  modport master (
    output resolve_valid, resolve_PC, resolve_target, resolve_taken, predicted_PC, btb_wr_ready,
    input  resolve_ready, mispredict, redirect_PC, btb_wr_valid, btb_wr_index, btb_wr_tag,
           btb_wr_target, pred_taken_hint, counter_state
  );
endinterface

// File: rtl/branch_resolve_update.sv
// Branch resolve: mispredict/redirect pulse, global 2-bit counter and a 4-deep BTB write FIFO.
// Optional BTB_INVALIDATE_EN: not-taken resolves push an invalid-marker entry (target 16'hFFFF).
module branch_resolve_update (
  input  logic                          clk,
  input  logic                          reset_n,
  branch_resolve_update_if.slave        bus
);
  typedef logic [31:0] entry_t;  // {tag, index, target}

  logic [1:0]  counter_q, counter_d;
  logic        mispredict_q, mispredict_d;
  logic [15:0] redirect_q, redirect_d;
  entry_t      mem_q [4];
  entry_t      mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;

  logic        fifo_full, fifo_empty;
  logic        accept, push, pop;
  logic [15:0] actual_next;
  entry_t      push_entry;
  entry_t      head;

  assign fifo_full   = (count_q == 3'd4);
  assign fifo_empty  = (count_q == 3'd0);
  // Ready comes from registered count only, so there is no path from btb_wr_ready.
  assign accept      = bus.resolve_valid && !fifo_full;
  assign pop         = !fifo_empty && bus.btb_wr_ready;
  assign actual_next = bus.resolve_taken ? bus.resolve_target : (bus.resolve_PC + 16'd1);

`ifdef BTB_INVALIDATE_EN
  assign push       = accept;
  assign push_entry = bus.resolve_taken ? {bus.resolve_PC, bus.resolve_target}
                                        : {bus.resolve_PC, 16'hFFFF};
`else
  assign push       = accept && bus.resolve_taken;
  assign push_entry = {bus.resolve_PC, bus.resolve_target};
`endif

  always_comb begin
    counter_d    = counter_q;
    mispredict_d = 1'b0;
    redirect_d   = redirect_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    if (accept) begin
      if (bus.resolve_taken && counter_q != 2'b11) counter_d = counter_q + 2'd1;
      else if (!bus.resolve_taken && counter_q != 2'b00) counter_d = counter_q - 2'd1;
      if (actual_next != bus.predicted_PC) begin
        mispredict_d = 1'b1;
        redirect_d   = actual_next;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;

    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter_q    <= 2'b00;
      mispredict_q <= 1'b0;
      redirect_q   <= 16'h0000;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      count_q      <= 3'd0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      counter_q    <= counter_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_q        <= mem_d;
    end
  end

  assign head                = mem_q[rd_ptr_q];
  assign bus.resolve_ready   = !fifo_full;
  assign bus.btb_wr_valid    = !fifo_empty;
  assign bus.btb_wr_tag      = head[31:24];
  assign bus.btb_wr_index    = head[23:16];
  assign bus.btb_wr_target   = head[15:0];
  assign bus.mispredict      = mispredict_q;
  assign bus.redirect_PC     = redirect_q;
  assign bus.counter_state   = counter_q;
  assign bus.pred_taken_hint = counter_q[1];
endmodule

// File: tb/tb_branch_resolve_update.sv
// Bench for branch_resolve_update: queue-based reference model, per-cycle compare, directed pins.
module tb_branch_resolve_update;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

`ifdef BTB_INVALIDATE_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  branch_resolve_update_if bus ();

  branch_resolve_update u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  int          m_cnt = 0;
  logic        m_mis = 1'b0;
  logic [15:0] m_redir = 16'h0000;

  initial begin : model
    bit          acc, pp;
    logic [15:0] nxt;
    logic [31:0] tmp;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        exp_q.delete();
        m_cnt = 0; m_mis = 1'b0; m_redir = 16'h0000;
      end else begin
        acc = bus.resolve_valid && (exp_q.size() < 4);
        pp  = (exp_q.size() > 0) && bus.btb_wr_ready;
        nxt = bus.resolve_taken ? bus.resolve_target : 16'(bus.resolve_PC + 16'd1);
        if (pp) tmp = exp_q.pop_front();
        if (acc && bus.resolve_taken) exp_q.push_back({bus.resolve_PC, bus.resolve_target});
        else if (acc && INV_EN) exp_q.push_back({bus.resolve_PC, 16'hFFFF});
        m_mis = acc && (nxt != bus.predicted_PC);
        if (m_mis) m_redir = nxt;
        if (acc) m_cnt = bus.resolve_taken ? ((m_cnt < 3) ? m_cnt + 1 : 3)
                                           : ((m_cnt > 0) ? m_cnt - 1 : 0);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge clk);
      chk("ready", 32'(bus.resolve_ready), 32'(exp_q.size() < 4));
      chk("wr_valid", 32'(bus.btb_wr_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0)
        chk("wr_entry", {bus.btb_wr_tag, bus.btb_wr_index, bus.btb_wr_target}, exp_q[0]);
      chk("mispredict", 32'(bus.mispredict), 32'(m_mis));
      chk("redirect", 32'(bus.redirect_PC), 32'(m_redir));
      chk("counter", 32'(bus.counter_state), 32'(m_cnt));
      chk("hint", 32'(bus.pred_taken_hint), 32'(m_cnt >= 2));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [15:0] pc, input logic [15:0] tgt,
                       input bit tk, input logic [15:0] pred);
    bus.resolve_valid  = v;
    bus.resolve_PC     = pc;
    bus.resolve_target = tgt;
    bus.resolve_taken  = tk;
    bus.predicted_PC   = pred;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain();
    int budget;
    bus.btb_wr_ready = 1'b1;
    budget = 0;
    while (bus.btb_wr_valid && budget < 10) begin
      step();
      budget++;
    end
    chk("drain_timeout", 32'(bus.btb_wr_valid), 32'd0);
  endtask

  initial begin : stim
    logic [1:0]  cnt_up[5];
    logic [1:0]  cnt_dn[5];
    logic [15:0] pc, tgt, nxt;
    bit          tk;
    cnt_up = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11};
    cnt_dn = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    idle();
    bus.btb_wr_ready = 1'b0;
    do_reset();
    chk("rst_counter", 32'(bus.counter_state), 32'd0);
    chk("rst_mispredict", 32'(bus.mispredict), 32'd0);
    chk("rst_redirect", 32'(bus.redirect_PC), 32'h0000);
    chk("rst_wr_valid", 32'(bus.btb_wr_valid), 32'd0);
    chk("rst_ready", 32'(bus.resolve_ready), 32'd1);

    // taken mispredict
    drive(1'b1, 16'h0010, 16'h0040, 1'b1, 16'h0011);
    step();
    idle();
    chk("t1_mispredict", 32'(bus.mispredict), 32'd1);
    chk("t1_redirect", 32'(bus.redirect_PC), 32'h0040);
    chk("t1_wr_valid", 32'(bus.btb_wr_valid), 32'd1);
    chk("t1_index", 32'(bus.btb_wr_index), 32'h10);
    chk("t1_tag", 32'(bus.btb_wr_tag), 32'h00);
    chk("t1_target", 32'(bus.btb_wr_target), 32'h0040);
    chk("t1_counter", 32'(bus.counter_state), 32'd1);
    step();
    chk("t1_pulse_end", 32'(bus.mispredict), 32'd0);
    chk("t1_redirect_hold", 32'(bus.redirect_PC), 32'h0040);

    // not-taken, correctly predicted
    drive(1'b1, 16'h0020, 16'h0099, 1'b0, 16'h0021);
    step();
    idle();
    chk("t2_mispredict", 32'(bus.mispredict), 32'd0);
    bus.btb_wr_ready = 1'b1;
    step();
    bus.btb_wr_ready = 1'b0;
    if (INV_EN) chk("t2_inv_target", 32'(bus.btb_wr_target), 32'hFFFF);
    else        chk("t2_no_push", 32'(bus.btb_wr_valid), 32'd0);
    drain();
    bus.btb_wr_ready = 1'b0;

    // fill to full with BTB stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(16'h0130 + i * 16'h0101), 16'(16'h2000 + i), 1'b1, 16'(16'h2000 + i));
      step();
    end
    chk("full_ready", 32'(bus.resolve_ready), 32'd0);
    drive(1'b1, 16'h0777, 16'h0888, 1'b1, 16'h0000);
    step();
    step();
    idle();
    chk("full_no_mispredict", 32'(bus.mispredict), 32'd0);
    bus.btb_wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("order_index", 32'(bus.btb_wr_index), 32'(8'h30 + i));
      chk("order_target", 32'(bus.btb_wr_target), 32'(16'h2000 + i));
      step();
    end
    chk("order_empty", 32'(bus.btb_wr_valid), 32'd0);

    // counter saturation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h0050, 16'h0060, 1'b1, 16'h0060);
      step();
      chk("cnt_up", 32'(bus.counter_state), 32'(cnt_up[i]));
      chk("hint_up", 32'(bus.pred_taken_hint), 32'(cnt_up[i][1]));
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h0050, 16'h0060, 1'b0, 16'h0051);
      step();
      chk("cnt_dn", 32'(bus.counter_state), 32'(cnt_dn[i]));
      chk("hint_dn", 32'(bus.pred_taken_hint), 32'(cnt_dn[i][1]));
    end

    // PC wrap
    drive(1'b1, 16'hFFFF, 16'h1234, 1'b0, 16'h0000);
    step();
    chk("wrap_ok", 32'(bus.mispredict), 32'd0);
    drive(1'b1, 16'hFFFE, 16'h1234, 1'b0, 16'h0000);
    step();
    idle();
    chk("wrap_mis", 32'(bus.mispredict), 32'd1);
    chk("wrap_redirect", 32'(bus.redirect_PC), 32'hFFFF);
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      pc  = 16'(16'hFF00 * $urandom_range(0, 1) + $urandom_range(0, 255));
      tgt = 16'($urandom);
      tk  = 1'($urandom_range(0, 1));
      nxt = tk ? tgt : 16'(pc + 16'd1);
      drive(1'($urandom_range(0, 3) != 0), pc, tgt, tk,
            ($urandom_range(0, 1) != 0) ? nxt : 16'($urandom));
      bus.btb_wr_ready = 1'($urandom_range(0, 2) == 0);
      step();
    end
    idle();
    drain();

    // reset mid-operation
    bus.btb_wr_ready = 1'b0;
    drive(1'b1, 16'h0A00, 16'h0B00, 1'b1, 16'h0B00);
    step();
    drive(1'b1, 16'h0A10, 16'h0C00, 1'b1, 16'h0A11);
    step();
    idle();
    chk("pre_rst_mispredict", 32'(bus.mispredict), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_mispredict", 32'(bus.mispredict), 32'd0);
    chk("mid_rst_redirect", 32'(bus.redirect_PC), 32'h0000);
    chk("mid_rst_wr_valid", 32'(bus.btb_wr_valid), 32'd0);
    chk("mid_rst_counter", 32'(bus.counter_state), 32'd0);
    chk("mid_rst_ready", 32'(bus.resolve_ready), 32'd1);
    step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("post_rst_wr_valid", 32'(bus.btb_wr_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
